apb_event_sink: RTL and testbench
=================================

Name: apb_event_sink

Overview:
- APB completer (slave) for the event-count write stream produced by the event-to-APB requester.
- Decodes the three event addresses and accumulates each received count into a saturating per-event total with a sticky overflow flag.
- Serves reads of the totals and the flags; inserts a fixed number of wait states; flags unmapped accesses with PSLVERR.
- Sits on the APB side as the terminating register block; totals are also exported as sideband outputs.

Parameters:
- WAIT_CYCLES, 0, access-phase cycles with pready low before pready is driven high (0 = zero-wait).
- CNT_W, 16, width of each accumulated total (legal range 4..32).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- apb_psel_i  in  1  APB select
- apb_penable_i  in  1  APB enable (access phase)
- apb_paddr_i  in  32  APB address
- apb_pwrite_i  in  1  1 = write, 0 = read
- apb_pwdata_i  in  32  write data
- apb_prdata_o  out  32  read data; valid only while pready_o=1 on a read
- apb_pready_o  out  1  transfer completion
- apb_pslverr_o  out  1  error response; valid only while pready_o=1
- clr_i  in  1  single-cycle clear of all totals and overflow flags
- total_a_o / total_b_o / total_c_o  out  CNT_W  current totals

Behaviour:
- Reset (synchronous): state=IDLE; totals=0; overflow flags=0; pready_o=0; pslverr_o=0; prdata_o=0.
- FSM states: IDLE, ACCESS.
  - IDLE: a setup phase (psel=1, penable=0) latches paddr, pwrite and pwdata, clears the wait counter, and moves to ACCESS.
  - IDLE: penable=1 without a preceding setup phase is ignored.
- ACCESS:
  - Wait counter below WAIT_CYCLES: increment, pready_o=0.
  - Wait counter equal to WAIT_CYCLES: pready_o=1 for exactly one cycle; the register update commits at that edge; return to IDLE.
  - pready_o, pslverr_o and prdata_o are decoded from registered state and latched address only, never combinationally from APB inputs.
  - psel=0 while in ACCESS (master abort): return to IDLE, no update, no pready.
- Latency with WAIT_CYCLES=0: setup cycle, then an access cycle with pready=1, i.e. 2 cycles per transfer.
- Back-to-back transfers are supported: a setup phase seen in IDLE on the cycle after pready starts the next transfer.
- Address map (exact 32-bit match):
  - 0xABBA0000: total A, RW.
  - 0xBAFF0000: total B, RW.
  - 0xCAFE0000: total C, RW.
  - 0xD0D00000: STATUS; bits [2:0] = overflow C, B, A; write-1-to-clear.
- Write to a total address: total <= total + pwdata[CNT_W-1:0].
  - Saturates at 2^CNT_W-1.
  - Any saturation or carry-out sets that event's sticky overflow flag.
  - Adding 0 is legal and leaves the total unchanged.
- Reads return the value zero-extended to 32 bits; STATUS reads as {29'b0, ovf}.
- Unmapped address (read or write): pslverr_o=1 together with pready_o, no state change, prdata_o=0.
- clr_i in the same cycle as a committing write to total X: total X <= pwdata[CNT_W-1:0] (clear then add); all other totals and all flags are cleared. No received event is lost.
- clr_i in the same cycle as a STATUS W1C write: clear wins.
- total_*_o reflect the registered totals (updated the cycle after commit).

Optional Feature:
- Macro: APB_EVENT_SINK_IRQ_EN.
- Defined:
  - Adds output irq_o (1 bit), registered: irq_o = OR of the overflow flags.
  - Rises the cycle after the flag is set; falls the cycle after the flags are cleared by W1C, clr_i or reset.
- Undefined:
  - irq_o port and its logic are absent.
  - Overflow remains visible only via STATUS.

Decomposition:
- Package events_apb_pkg:
  - address constants ADDR_EVENT_A/B/C and ADDR_STATUS;
  - state_t enum {IDLE, ACCESS};
  - event index enum shared with the requester.
- Sub-module event_accum, instantiated 3x:
  - CNT_W saturating adder, sticky overflow, clear and W1C inputs;
  - encapsulates the clear-then-add priority rule.

Test Plan:
- WAIT_CYCLES=0; write 0x3 to 0xABBA0000 → pready high on the 2nd cycle, pslverr=0, total_a_o=3 the next cycle; read 0xABBA0000 → prdata=0x00000003.
- WAIT_CYCLES=2; write 0x5 to 0xCAFE0000 → pready low for 2 access cycles, high on the 3rd, total_c_o=5; back-to-back write 0x1 → total_c_o=6.
- CNT_W=4; total_b=14, write 0x5 → total_b=15 (saturated), STATUS reads 0x2; W1C write 0x2 → STATUS=0, total_b stays 15.
- Read from 0x12340000 → pready=1 with pslverr=1, prdata=0; all totals unchanged.
- total_a=7; clr_i pulsed on the commit cycle of a write of 0x4 to A → total_a=4, total_b=total_c=0, STATUS=0.
- Reset asserted mid-ACCESS → next cycle state IDLE, pready=0, all totals 0; with APB_EVENT_SINK_IRQ_EN, force an overflow → irq_o=1 one cycle after the flag, and 0 after W1C.

Source files
------------

// File: rtl/events_apb_pkg.sv
// Shared definitions for the event-count APB slice: address map, FSM states,
// event indices, the latched APB request payload and the address decoder.
package events_apb_pkg;

   localparam logic [31:0] ADDR_EVENT_A = 32'hABBA_0000;
   localparam logic [31:0] ADDR_EVENT_B = 32'hBAFF_0000;
   localparam logic [31:0] ADDR_EVENT_C = 32'hCAFE_0000;
   localparam logic [31:0] ADDR_STATUS  = 32'hD0D0_0000;

   localparam int unsigned NUM_EVENTS = 3;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   // Event index shared with the requester; also the STATUS bit position.
   typedef enum logic [1:0] {
      EV_A = 2'd0,
      EV_B = 2'd1,
      EV_C = 2'd2
   } event_idx_t;

   typedef enum logic [2:0] {
      DEC_EV_A,
      DEC_EV_B,
      DEC_EV_C,
      DEC_STATUS,
      DEC_NONE
   } dec_t;

   // Request captured in the setup phase and held through the access phase.
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
   } apb_req_t;

   // Exact 32-bit match against the register map.
   function automatic dec_t addr_decode(input logic [31:0] addr);
      dec_t dec;
      case (addr)
         ADDR_EVENT_A: dec = DEC_EV_A;
         ADDR_EVENT_B: dec = DEC_EV_B;
         ADDR_EVENT_C: dec = DEC_EV_C;
         ADDR_STATUS:  dec = DEC_STATUS;
         default:      dec = DEC_NONE;
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/event_accum.sv
// Saturating per-event accumulator with sticky overflow flag.
// A clear in the same cycle as an add resets the total first and then adds,
// so the event arriving with the clear is not lost; clear also beats W1C.
module event_accum #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             add_en_i,
   input  logic [CNT_W-1:0] add_val_i,
   input  logic             w1c_i,
   output logic [CNT_W-1:0] total_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] total_q, total_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] base;
   logic [CNT_W:0]   sum;

   // Next total/flag: clear, then add with saturation on carry-out.
   always_comb begin
      base    = clr_i ? '0 : total_q;
      sum     = {1'b0, base} + {1'b0, add_val_i};
      total_d = base;
      ovf_d   = clr_i ? 1'b0 : (ovf_q & ~w1c_i);
      if (add_en_i) begin
         if (sum[CNT_W]) begin
            total_d = '1;
            ovf_d   = 1'b1;
         end else begin
            total_d = sum[CNT_W-1:0];
         end
      end
   end

   // Total and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         total_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         total_q <= total_d;
         ovf_q   <= ovf_d;
      end
   end

   assign total_o = total_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/apb_event_sink.sv
// APB completer terminating the event-count write stream. Accumulates writes
// into three saturating totals, serves reads of totals and STATUS, inserts
// WAIT_CYCLES wait states and flags unmapped accesses with PSLVERR.
// Optional: define APB_EVENT_SINK_IRQ_EN to add the registered irq_o output.
module apb_event_sink
   import events_apb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             apb_psel_i,
   input  logic             apb_penable_i,
   input  logic [31:0]      apb_paddr_i,
   input  logic             apb_pwrite_i,
   input  logic [31:0]      apb_pwdata_i,
   output logic [31:0]      apb_prdata_o,
   output logic             apb_pready_o,
   output logic             apb_pslverr_o,
   input  logic             clr_i,
   output logic [CNT_W-1:0] total_a_o,
   output logic [CNT_W-1:0] total_b_o,
   output logic [CNT_W-1:0] total_c_o
`ifdef APB_EVENT_SINK_IRQ_EN
   ,
   output logic             irq_o
`endif
);

   localparam int unsigned WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     cnt_q, cnt_d;
   apb_req_t              req_q, req_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [31:0]           prdata_q, prdata_d;
   logic                  commit, resp_en;
   dec_t                  dec_cur, dec_nxt;
   logic [NUM_EVENTS-1:0] add_en, w1c, ovf;
   logic [CNT_W-1:0]      total_a, total_b, total_c;

   assign dec_cur = addr_decode(req_q.addr);
   assign dec_nxt = addr_decode(req_d.addr);

   // Transfer FSM; the response is prepared one edge ahead so it leaves a flop.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      commit    = 1'b0;
      resp_en   = 1'b0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      case (state_q)
         IDLE: begin
            if (apb_psel_i && !apb_penable_i) begin
               state_d     = ACCESS;
               cnt_d       = '0;
               req_d.addr  = apb_paddr_i;
               req_d.write = apb_pwrite_i;
               req_d.wdata = apb_pwdata_i;
               resp_en     = (WAIT_CYCLES == 0);
            end
         end
         ACCESS: begin
            if (!apb_psel_i) begin
               state_d = IDLE;
            end else if (cnt_q == WAIT_W'(WAIT_CYCLES)) begin
               commit  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + WAIT_W'(1);
               resp_en = ((32'(cnt_q) + 32'd1) == 32'(WAIT_CYCLES));
            end
         end
         default: state_d = IDLE;
      endcase
      if (resp_en) begin
         pready_d  = 1'b1;
         pslverr_d = (dec_nxt == DEC_NONE);
         if (!req_d.write) begin
            case (dec_nxt)
               DEC_EV_A:   prdata_d = 32'(total_a);
               DEC_EV_B:   prdata_d = 32'(total_b);
               DEC_EV_C:   prdata_d = 32'(total_c);
               DEC_STATUS: prdata_d = 32'(ovf);
               default:    prdata_d = '0;
            endcase
         end
      end
   end

   // Per-event add and W1C strobes for the committing write.
   always_comb begin
      add_en       = '0;
      w1c          = '0;
      add_en[EV_A] = commit && req_q.write && (dec_cur == DEC_EV_A);
      add_en[EV_B] = commit && req_q.write && (dec_cur == DEC_EV_B);
      add_en[EV_C] = commit && req_q.write && (dec_cur == DEC_EV_C);
      if (commit && req_q.write && (dec_cur == DEC_STATUS)) begin
         w1c = req_q.wdata[NUM_EVENTS-1:0];
      end
   end

   // FSM, latched request and registered APB response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   event_accum #(.CNT_W(CNT_W)) u_accum_a (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (clr_i),
      .add_en_i  (add_en[EV_A]),
      .add_val_i (req_q.wdata[CNT_W-1:0]),
      .w1c_i     (w1c[EV_A]),
      .total_o   (total_a),
      .ovf_o     (ovf[EV_A])
   );

   event_accum #(.CNT_W(CNT_W)) u_accum_b (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (clr_i),
      .add_en_i  (add_en[EV_B]),
      .add_val_i (req_q.wdata[CNT_W-1:0]),
      .w1c_i     (w1c[EV_B]),
      .total_o   (total_b),
      .ovf_o     (ovf[EV_B])
   );

   event_accum #(.CNT_W(CNT_W)) u_accum_c (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (clr_i),
      .add_en_i  (add_en[EV_C]),
      .add_val_i (req_q.wdata[CNT_W-1:0]),
      .w1c_i     (w1c[EV_C]),
      .total_o   (total_c),
      .ovf_o     (ovf[EV_C])
   );

`ifdef APB_EVENT_SINK_IRQ_EN
   logic irq_q, irq_d;

   // Interrupt follows the flags one cycle late.
   always_comb begin
      irq_d = |ovf;
   end

   // Interrupt register.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_o = irq_q;
`endif

   assign apb_pready_o  = pready_q;
   assign apb_pslverr_o = pslverr_q;
   assign apb_prdata_o  = prdata_q;
   assign total_a_o     = total_a;
   assign total_b_o     = total_b;
   assign total_c_o     = total_c;

endmodule

// File: tb/tb_apb_event_sink.sv
// Bench for apb_event_sink: two instances (zero-wait 16-bit, two-wait 4-bit)
// driven by directed scenarios and random transfers against a register model.
module tb_apb_event_sink;

   localparam int unsigned W0 = 0;
   localparam int unsigned C0 = 16;
   localparam int unsigned W1 = 2;
   localparam int unsigned C1 = 4;

   localparam logic [31:0] A_A = 32'hABBA_0000;
   localparam logic [31:0] A_B = 32'hBAFF_0000;
   localparam logic [31:0] A_C = 32'hCAFE_0000;
   localparam logic [31:0] A_S = 32'hD0D0_0000;
   localparam logic [31:0] A_U = 32'h1234_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [1:0]       psel, penable, pwrite, clr;
   logic [1:0][31:0] paddr, pwdata;
   logic [1:0]       pready, pslverr;
   logic [1:0][31:0] prdata;
   logic             rdy0, rdy1, err0, err1;
   logic [31:0]      rd0, rd1;
   logic [C0-1:0]    ta0, tb0, tc0;
   logic [C1-1:0]    ta1, tb1, tc1;
`ifdef APB_EVENT_SINK_IRQ_EN
   logic             irq0, irq1;
`endif

   assign pready  = {rdy1, rdy0};
   assign pslverr = {err1, err0};
   assign prdata  = {rd1, rd0};

   int tests_run = 0;
   int fails     = 0;

   // Reference register model.
   int unsigned mtot [2][3];
   logic [2:0]  movf [2];

   apb_event_sink #(.WAIT_CYCLES(W0), .CNT_W(C0)) dut0 (
      .clk           (clk),
      .reset         (reset),
      .apb_psel_i    (psel[0]),
      .apb_penable_i (penable[0]),
      .apb_paddr_i   (paddr[0]),
      .apb_pwrite_i  (pwrite[0]),
      .apb_pwdata_i  (pwdata[0]),
      .apb_prdata_o  (rd0),
      .apb_pready_o  (rdy0),
      .apb_pslverr_o (err0),
      .clr_i         (clr[0]),
      .total_a_o     (ta0),
      .total_b_o     (tb0),
      .total_c_o     (tc0)
`ifdef APB_EVENT_SINK_IRQ_EN
      ,
      .irq_o         (irq0)
`endif
   );

   apb_event_sink #(.WAIT_CYCLES(W1), .CNT_W(C1)) dut1 (
      .clk           (clk),
      .reset         (reset),
      .apb_psel_i    (psel[1]),
      .apb_penable_i (penable[1]),
      .apb_paddr_i   (paddr[1]),
      .apb_pwrite_i  (pwrite[1]),
      .apb_pwdata_i  (pwdata[1]),
      .apb_prdata_o  (rd1),
      .apb_pready_o  (rdy1),
      .apb_pslverr_o (err1),
      .clr_i         (clr[1]),
      .total_a_o     (ta1),
      .total_b_o     (tb1),
      .total_c_o     (tc1)
`ifdef APB_EVENT_SINK_IRQ_EN
      ,
      .irq_o         (irq1)
`endif
   );

   function automatic longint mmax(input int w);
      return (w == 0) ? longint'((64'd1 << C0) - 1) : longint'((64'd1 << C1) - 1);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      if (a == A_A) return 0;
      if (a == A_B) return 1;
      if (a == A_C) return 2;
      return -1;
   endfunction

   function automatic logic [31:0] model_read(input int w, input logic [31:0] a);
      if (idx_of(a) >= 0) return mtot[w][idx_of(a)];
      if (a == A_S) return {29'd0, movf[w]};
      return 32'd0;
   endfunction

   function automatic void model_clear(input int w);
      for (int i = 0; i < 3; i++) mtot[w][i] = 0;
      movf[w] = 3'b000;
   endfunction

   // Effect of one committed transfer: clear first, then add or W1C.
   function automatic void model_commit(input int w, input bit wr, input logic [31:0] a,
                                        input logic [31:0] d, input bit clr_now);
      longint s;
      int     i;
      if (clr_now) model_clear(w);
      if (!wr) return;
      i = idx_of(a);
      if (i >= 0) begin
         s = longint'(mtot[w][i]) + longint'(d & 32'(mmax(w)));
         if (s > mmax(w)) begin
            mtot[w][i] = 32'(mmax(w));
            movf[w][i] = 1'b1;
         end else begin
            mtot[w][i] = 32'(s);
         end
      end else if (a == A_S && !clr_now) begin
         movf[w] = movf[w] & ~d[2:0];
      end
   endfunction

   function automatic logic [31:0] sb(input int w, input int i);
      if (w == 0) return (i == 0) ? 32'(ta0) : (i == 1) ? 32'(tb0) : 32'(tc0);
      return (i == 0) ? 32'(ta1) : (i == 1) ? 32'(tb1) : 32'(tc1);
   endfunction

   // One APB transfer; returns at the negedge where pready is seen, bus held.
   task automatic xfer(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit clr_commit, output logic [31:0] rd, output logic err,
                       output int waits);
      int n;
      @(negedge clk);
      psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = a; pwdata[w] = d;
      @(negedge clk);
      penable[w] = 1'b1;
      n = 0;
      while (pready[w] !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      waits = n;
      rd    = prdata[w];
      err   = pslverr[w];
      if (pready[w] !== 1'b1) begin
         tests_run++; fails++;
         $display("FAIL xfer_timeout dut%0d addr=%h: no pready after %0d cycles", w, a, n);
      end else begin
         if (clr_commit) clr[w] = 1'b1;
         model_commit(w, wr, a, d, clr_commit);
      end
   endtask

   task automatic bus_idle(input int w);
      @(negedge clk);
      psel[w] = 1'b0; penable[w] = 1'b0; clr[w] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; psel = '0; penable = '0; pwrite = '0; clr = '0; paddr = '0; pwdata = '0;
      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         model_clear(w);
         tests_run++;
         if (pready[w] !== 1'b0 || pslverr[w] !== 1'b0 || prdata[w] !== 32'd0) begin
            fails++;
            $display("FAIL reset_resp dut%0d: got rdy=%b err=%b rd=%h want 0/0/0", w, pready[w], pslverr[w], prdata[w]);
         end
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (sb(w, i) !== 32'd0) begin
               fails++; $display("FAIL reset_total dut%0d[%0d]: got %h want 0", w, i, sb(w, i));
            end
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_wait0();
      logic [31:0] rd; logic err; int waits;
      xfer(0, 1'b1, A_A, 32'h3, 1'b0, rd, err, waits);
      tests_run++;
      if (waits !== 0 || err !== 1'b0) begin
         fails++; $display("FAIL wait0_write: got waits=%0d err=%b want 0/0", waits, err);
      end
      bus_idle(0);
      tests_run++;
      if (pready[0] !== 1'b0 || sb(0, 0) !== 32'd3) begin
         fails++; $display("FAIL wait0_total: got rdy=%b total_a=%h want 0/3", pready[0], sb(0, 0));
      end
      xfer(0, 1'b0, A_A, 32'h0, 1'b0, rd, err, waits);
      bus_idle(0);
      tests_run++;
      if (rd !== 32'h3 || err !== 1'b0 || waits !== 0) begin
         fails++; $display("FAIL wait0_read: got rd=%h err=%b waits=%0d want 3/0/0", rd, err, waits);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic err; int w1, w2;
      xfer(1, 1'b1, A_C, 32'h5, 1'b0, rd, err, w1);
      bus_idle(1);
      tests_run++;
      if (w1 !== 2 || sb(1, 2) !== 32'd5) begin
         fails++; $display("FAIL wait2_write: got waits=%0d total_c=%h want 2/5", w1, sb(1, 2));
      end
      xfer(1, 1'b1, A_C, 32'h1, 1'b0, rd, err, w1);
      xfer(1, 1'b1, A_B, 32'h2, 1'b0, rd, err, w2);
      bus_idle(1);
      tests_run++;
      if (w1 !== 2 || w2 !== 2 || sb(1, 2) !== 32'd6 || sb(1, 1) !== 32'd2) begin
         fails++;
         $display("FAIL back_to_back: got waits=%0d/%0d c=%h b=%h want 2/2 6 2", w1, w2, sb(1, 2), sb(1, 1));
      end
   endtask

   task automatic test_saturation();
      logic [31:0] rd; logic err; int waits;
      xfer(1, 1'b1, A_B, 32'd12, 1'b0, rd, err, waits);
      xfer(1, 1'b1, A_B, 32'd5, 1'b0, rd, err, waits);
      bus_idle(1);
      tests_run++;
      if (sb(1, 1) !== 32'd15) begin
         fails++; $display("FAIL sat_total: got %h want f", sb(1, 1));
      end
      xfer(1, 1'b0, A_S, 32'h0, 1'b0, rd, err, waits);
      tests_run++;
      if (rd !== 32'h2) begin
         fails++; $display("FAIL sat_status: got %h want 2", rd);
      end
`ifdef APB_EVENT_SINK_IRQ_EN
      bus_idle(1);
      tests_run++;
      if (irq1 !== 1'b1) begin
         fails++; $display("FAIL irq_set: got %b want 1", irq1);
      end
`endif
      xfer(1, 1'b1, A_S, 32'h2, 1'b0, rd, err, waits);
      bus_idle(1);
`ifdef APB_EVENT_SINK_IRQ_EN
      tests_run++;
      if (irq1 !== 1'b1) begin
         fails++; $display("FAIL irq_hold: got %b want 1 one cycle after W1C", irq1);
      end
      @(negedge clk);
      tests_run++;
      if (irq1 !== 1'b0) begin
         fails++; $display("FAIL irq_clear: got %b want 0", irq1);
      end
`endif
      xfer(1, 1'b0, A_S, 32'h0, 1'b0, rd, err, waits);
      bus_idle(1);
      tests_run++;
      if (rd !== 32'h0 || sb(1, 1) !== 32'd15) begin
         fails++; $display("FAIL w1c: got status=%h total_b=%h want 0/f", rd, sb(1, 1));
      end
   endtask

`ifdef APB_EVENT_SINK_IRQ_EN
   task automatic test_irq();
      logic [31:0] rd; logic err; int waits;
      xfer(1, 1'b1, A_A, 32'hF, 1'b0, rd, err, waits);
      xfer(1, 1'b1, A_A, 32'h1, 1'b0, rd, err, waits);
      bus_idle(1);
      tests_run++;
      if (irq1 !== 1'b0) begin
         fails++; $display("FAIL irq_delay: got %b want 0 on flag cycle", irq1);
      end
      @(negedge clk);
      tests_run++;
      if (irq1 !== 1'b1) begin
         fails++; $display("FAIL irq_rise: got %b want 1", irq1);
      end
      xfer(1, 1'b1, A_S, 32'h1, 1'b0, rd, err, waits);
      bus_idle(1);
      @(negedge clk);
      tests_run++;
      if (irq1 !== 1'b0) begin
         fails++; $display("FAIL irq_fall: got %b want 0", irq1);
      end
   endtask
`endif

   task automatic test_unmapped();
      logic [31:0] rd; logic err; int waits;
      for (int w = 0; w < 2; w++) begin
         xfer(w, 1'b0, A_U, 32'h0, 1'b0, rd, err, waits);
         tests_run++;
         if (err !== 1'b1 || rd !== 32'd0) begin
            fails++; $display("FAIL unmapped_read dut%0d: got err=%b rd=%h want 1/0", w, err, rd);
         end
         xfer(w, 1'b1, A_U ^ 32'h4, 32'hFFFF_FFFF, 1'b0, rd, err, waits);
         bus_idle(w);
         tests_run++;
         if (err !== 1'b1 || pready[w] !== 1'b0) begin
            fails++; $display("FAIL unmapped_write dut%0d: got err=%b rdy_after=%b want 1/0", w, err, pready[w]);
         end
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (sb(w, i) !== mtot[w][i]) begin
               fails++; $display("FAIL unmapped_total dut%0d[%0d]: got %h want %h", w, i, sb(w, i), mtot[w][i]);
            end
         end
      end
   endtask

   task automatic test_clear_add();
      logic [31:0] rd; logic err; int waits;
      @(negedge clk); clr[0] = 1'b1;
      @(negedge clk); clr[0] = 1'b0;
      model_clear(0);
      xfer(0, 1'b1, A_A, 32'h7, 1'b0, rd, err, waits);
      xfer(0, 1'b1, A_B, 32'h9, 1'b0, rd, err, waits);
      xfer(0, 1'b1, A_C, 32'hFFFF, 1'b0, rd, err, waits);
      xfer(0, 1'b1, A_C, 32'h2, 1'b0, rd, err, waits);
      xfer(0, 1'b1, A_A, 32'h4, 1'b1, rd, err, waits);
      bus_idle(0);
      tests_run++;
      if (sb(0, 0) !== 32'd4 || sb(0, 1) !== 32'd0 || sb(0, 2) !== 32'd0) begin
         fails++; $display("FAIL clr_add: got a=%h b=%h c=%h want 4/0/0", sb(0, 0), sb(0, 1), sb(0, 2));
      end
      xfer(0, 1'b0, A_S, 32'h0, 1'b0, rd, err, waits);
      bus_idle(0);
      tests_run++;
      if (rd !== 32'h0) begin
         fails++; $display("FAIL clr_status: got %h want 0", rd);
      end
      xfer(0, 1'b1, A_B, 32'hFFFF, 1'b0, rd, err, waits);
      xfer(0, 1'b1, A_B, 32'hFFFF, 1'b0, rd, err, waits);
      xfer(0, 1'b1, A_S, 32'h0, 1'b1, rd, err, waits);
      xfer(0, 1'b0, A_S, 32'h0, 1'b0, rd, err, waits);
      bus_idle(0);
      tests_run++;
      if (rd !== 32'h0 || sb(0, 1) !== 32'd0) begin
         fails++; $display("FAIL clr_vs_w1c: got status=%h b=%h want 0/0", rd, sb(0, 1));
      end
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic err; int waits; int seen;
      seen = 0;
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = A_A; pwdata[1] = 32'h3;
      @(negedge clk); penable[1] = 1'b1;
      @(negedge clk); psel[1] = 1'b0; penable[1] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (pready[1] === 1'b1) seen++;
      end
      tests_run++;
      if (seen != 0 || sb(1, 0) !== mtot[1][0]) begin
         fails++; $display("FAIL abort: got pready_cycles=%0d a=%h want 0/%h", seen, sb(1, 0), mtot[1][0]);
      end
      seen = 0;
      @(negedge clk);
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = A_A; pwdata[0] = 32'h5;
      repeat (4) begin
         @(negedge clk);
         if (pready[0] === 1'b1) seen++;
      end
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge clk);
      tests_run++;
      if (seen != 0 || sb(0, 0) !== mtot[0][0]) begin
         fails++; $display("FAIL penable_only: got pready_cycles=%0d a=%h want 0/%h", seen, sb(0, 0), mtot[0][0]);
      end
      xfer(1, 1'b1, A_A, 32'h1, 1'b0, rd, err, waits);
      bus_idle(1);
      tests_run++;
      if (waits !== 2 || sb(1, 0) !== mtot[1][0]) begin
         fails++; $display("FAIL after_abort: got waits=%0d a=%h want 2/%h", waits, sb(1, 0), mtot[1][0]);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d, rd, exp_rd; logic err, exp_err; int waits; bit wr, cc; int k;
      for (int w = 0; w < 2; w++) begin
         for (int it = 0; it < 120; it++) begin
            k = $urandom_range(0, 5);
            case (k)
               0: a = A_A;
               1: a = A_B;
               2: a = A_C;
               3: a = A_S;
               default: begin
                  a = $urandom;
                  if (idx_of(a) >= 0 || a == A_S) a = a ^ 32'h1;
               end
            endcase
            d  = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(0, 9));
            wr = 1'($urandom_range(0, 1));
            cc = ($urandom_range(0, 11) == 0);
            exp_rd  = model_read(w, a);
            exp_err = (idx_of(a) < 0 && a != A_S);
            xfer(w, wr, a, d, cc, rd, err, waits);
            bus_idle(w);
            tests_run++;
            if (waits !== int'((w == 0) ? W0 : W1) || err !== exp_err || (!wr && rd !== exp_rd)) begin
               fails++;
               $display("FAIL rand_resp dut%0d it%0d addr=%h wr=%b: got waits=%0d err=%b rd=%h want %0d/%b/%h",
                        w, it, a, wr, waits, err, rd, (w == 0) ? W0 : W1, exp_err, exp_rd);
            end
            for (int i = 0; i < 3; i++) begin
               tests_run++;
               if (sb(w, i) !== mtot[w][i]) begin
                  fails++; $display("FAIL rand_total dut%0d it%0d [%0d]: got %h want %h", w, it, i, sb(w, i), mtot[w][i]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic err; int waits;
      @(negedge clk);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = A_B; pwdata[1] = 32'h3;
      @(negedge clk); penable[1] = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
      model_clear(0); model_clear(1);
      tests_run++;
      if (pready[1] !== 1'b0 || sb(1, 0) !== 32'd0 || sb(1, 1) !== 32'd0 || sb(1, 2) !== 32'd0 || sb(0, 0) !== 32'd0) begin
         fails++;
         $display("FAIL reset_mid: got rdy=%b a1=%h b1=%h c1=%h a0=%h want 0/0/0/0/0", pready[1], sb(1, 0), sb(1, 1), sb(1, 2), sb(0, 0));
      end
      xfer(1, 1'b1, A_B, 32'h3, 1'b0, rd, err, waits);
      bus_idle(1);
      tests_run++;
      if (waits !== 2 || sb(1, 1) !== 32'd3) begin
         fails++; $display("FAIL reset_recover: got waits=%0d b=%h want 2/3", waits, sb(1, 1));
      end
   endtask

   initial begin
      test_reset();
      test_wait0();
      test_back_to_back();
      test_saturation();
`ifdef APB_EVENT_SINK_IRQ_EN
      test_irq();
`endif
      test_unmapped();
      test_clear_add();
      test_abort();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
